if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 233 +++++++++++++++++++++++
 tb/tb_if_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: reads each 64-bit instruction as two 32-bit words and presents it to decode.
// Defining IF_ACK_TIMEOUT_EN adds an ack watchdog that parks the stage in IDLE and raises fetch_err_o.
module if_fetch #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ack_i,
  output logic [31:0] id_pc_o,
  output logic [63:0] id_inst_o,
  output logic        id_valid_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [63:0] hold_inst_q, hold_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [63:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  logic        fetch_s;
  logic        redirect_s;
  logic        slot_free_s;
  logic        timeout_s;
  logic        load_s;
  logic [31:0] load_pc_s;
  logic [63:0] load_inst_s;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("if_fetch: TIMEOUT_CYC must be at least 1");
  end

  assign fetch_s     = (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign redirect_s  = flush_i || branch_flag_i;
  assign slot_free_s = !id_valid_q || !stall_i;

  // Gating with rst drops the request the instant reset asserts, abandoning any outstanding fetch.
  assign imem_req_o  = rst && fetch_s;
  assign imem_addr_o = (state_q == FETCH_HI) ? (pc_q + 32'd4) : pc_q;

  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;
  assign id_valid_o  = id_valid_q;

`ifdef IF_ACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc_s;
  logic            err_q, err_d;

  assign wdog_inc_s  = wdog_q + WD_W'(1);
  assign fetch_err_o = err_q;

  // Watchdog: counts consecutive unacked request cycles; any gap or ack restarts it.
  always_comb begin
    wdog_d    = {WD_W{1'b0}};
    timeout_s = 1'b0;
    if (redirect_s) begin
      wdog_d = {WD_W{1'b0}};
    end else if (fetch_s && !imem_ack_i) begin
      if (wdog_inc_s == WD_W'(TIMEOUT_CYC)) begin
        timeout_s = 1'b1;
        wdog_d    = {WD_W{1'b0}};
      end else begin
        wdog_d = wdog_inc_s;
      end
    end else begin
      wdog_d = {WD_W{1'b0}};
    end
  end

  // Sticky error flag, cleared only by flush.
  always_comb begin
    err_d = err_q;
    if (flush_i) begin
      err_d = 1'b0;
    end else if (timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Watchdog and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= {WD_W{1'b0}};
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
`else
  assign timeout_s   = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  // Next-state, PC, word assembly, hold buffer and decode-slot update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    lo_d        = lo_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    load_s      = 1'b0;
    load_pc_s   = pc_q;
    load_inst_s = {lo_q, imem_rdata_i};

    if (redirect_s) begin
      // Any ack arriving with a redirect belongs to the abandoned stream and is dropped.
      state_d     = FETCH_LO;
      pc_d        = branch_target_i;
      lo_d        = 32'h0000_0000;
      hold_pc_d   = 32'h0000_0000;
      hold_inst_d = 64'h0000_0000_0000_0000;
      if (flush_i) begin
        id_valid_d = 1'b0;
        id_inst_d  = 64'h0000_0000_0000_0000;
      end else begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
      end
    end else begin
      case (state_q)
        FETCH_LO: begin
          if (imem_ack_i) begin
            lo_d    = imem_rdata_i;
            state_d = FETCH_HI;
          end else begin
            state_d = FETCH_LO;
          end
        end
        FETCH_HI: begin
          if (imem_ack_i) begin
            if (slot_free_s) begin
              load_s  = 1'b1;
              pc_d    = pc_q + 32'd8;
              state_d = FETCH_LO;
            end else begin
              hold_inst_d = {lo_q, imem_rdata_i};
              hold_pc_d   = pc_q;
              state_d     = HOLD;
            end
          end else begin
            state_d = FETCH_HI;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            load_s      = 1'b1;
            load_pc_s   = hold_pc_q;
            load_inst_s = hold_inst_q;
            pc_d        = hold_pc_q + 32'd8;
            state_d     = FETCH_LO;
          end else begin
            state_d = HOLD;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = FETCH_LO;
        end
      endcase

      if (timeout_s) begin
        state_d = IDLE;
      end else begin
        state_d = state_d;
      end

      // An unstalled edge without a new load consumes the slot and leaves an all-zero bubble.
      if (load_s) begin
        id_pc_d    = load_pc_s;
        id_inst_d  = load_inst_s;
        id_valid_d = 1'b1;
      end else if (!stall_i) begin
        id_valid_d = 1'b0;
        id_inst_d  = 64'h0000_0000_0000_0000;
      end else begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
      end
    end
  end

  // State, PC, assembly and decode-slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH_LO;
      pc_q        <= PC_RESET;
      lo_q        <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
      hold_inst_q <= 64'h0000_0000_0000_0000;
      id_pc_q     <= 32'h0000_0000;
      id_inst_q   <= 64'h0000_0000_0000_0000;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      lo_q        <= lo_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a transaction-level model predicts fetch addresses
// and the stream of instructions delivered to decode; a monitor compares every cycle.
module tb_if_fetch;

  localparam logic [31:0] PC_RST = 32'h0000_0000;
  localparam int          TO     = 16;
  localparam int PH_IDLE = 0, PH_LO = 1, PH_HI = 2, PH_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [63:0] id_inst_o;
  logic        id_valid_o;
  logic        fetch_err_o;

  if_fetch #(.PC_RESET(PC_RST), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
    .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'hAAAA_0001;
    else if (a == 32'h0000_0004) return 32'h5555_0002;
    else return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
  } ent_t;

  ent_t        exp_q[$];          // fetched, not yet consumed by decode (front = on id_*)
  logic [31:0] m_na = PC_RST;     // address of the instruction being fetched
  int          m_phase = PH_LO;
  int          m_wd = 0;
  bit          m_err = 1'b0;
  bit          m_req_was, m_free;
  ent_t        m_e;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      exp_q.delete();
      m_na = PC_RST; m_phase = PH_LO; m_wd = 0; m_err = 1'b0;
    end else if (flush_i) begin
      exp_q.delete();
      m_na = branch_target_i; m_phase = PH_LO; m_wd = 0; m_err = 1'b0;
    end else if (branch_flag_i) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      m_na = branch_target_i; m_phase = PH_LO; m_wd = 0;
    end else begin
      m_req_was = (m_phase == PH_LO) || (m_phase == PH_HI);
      m_free = (exp_q.size() == 0) || !stall_i;
      if (exp_q.size() != 0 && !stall_i) void'(exp_q.pop_front());
      if (m_phase == PH_LO && imem_ack_i) m_phase = PH_HI;
      else if (m_phase == PH_HI && imem_ack_i) begin
        m_e.pc = m_na;
        m_e.inst = {mem_word(m_na), mem_word(m_na + 32'd4)};
        exp_q.push_back(m_e);
        m_na = m_na + 32'd8;
        m_phase = m_free ? PH_LO : PH_HOLD;
      end else if (m_phase == PH_HOLD && !stall_i) m_phase = PH_LO;
`ifdef IF_ACK_TIMEOUT_EN
      if (m_req_was && !imem_ack_i) begin
        m_wd++;
        if (m_wd == TO) begin m_phase = PH_IDLE; m_err = 1'b1; m_wd = 0; end
      end else m_wd = 0;
`endif
    end
  end

  // ---------------- monitor ----------------
  bit mon_req;
  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      check("id_valid", id_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("id_pc", id_pc_o, exp_q[0].pc);
        check("id_inst", id_inst_o, exp_q[0].inst);
      end else begin
        check("id_inst_bubble", id_inst_o, 64'h0);
      end
      mon_req = (m_phase == PH_LO) || (m_phase == PH_HI);
      check("imem_req", imem_req_o, mon_req);
      if (mon_req) check("imem_addr", imem_addr_o, (m_phase == PH_HI) ? m_na + 32'd4 : m_na);
      check("fetch_err", fetch_err_o, m_err);
    end
  end

  // ---------------- stimulus ----------------
  int wleft = 0, w_lo = 0, w_hi = 0;
  bit no_ack = 1'b0;

  task automatic respond();
    imem_ack_i = 1'b0;
    imem_rdata_i = 32'h0;
    if (imem_req_o && !no_ack) begin
      if (wleft == 0) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
        wleft = int'($urandom_range(w_hi, w_lo));
      end else wleft--;
    end
  endtask

  task automatic step(input bit st, input bit fl, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    stall_i = st; flush_i = fl; branch_flag_i = br; branch_target_i = tgt;
    #1;
    respond();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    respond();
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int lat;
  logic [31:0] r_tgt;
  bit r_st, r_fl, r_br;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, PC_RST);
    check("rst_id_pc", id_pc_o, 32'h0);
    check("rst_id_inst", id_inst_o, 64'h0);
    check("rst_id_valid", id_valid_o, 1'b0);
    check("rst_err", fetch_err_o, 1'b0);

    // zero-wait first instruction
    release_rst();
    wait_edge();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("first_valid", id_valid_o, 1'b1);
    check("first_inst", id_inst_o, 64'hAAAA_0001_5555_0002);
    check("first_pc", id_pc_o, 32'h0);
    check("first_next_addr", imem_addr_o, 32'h8);

    // stall for 5 cycles while the second instruction completes
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      wait_edge();
    end
    check("hold_req", imem_req_o, 1'b0);
    check("hold_id_pc", id_pc_o, 32'h0);
    check("hold_id_inst", id_inst_o, 64'hAAAA_0001_5555_0002);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("release_pc", id_pc_o, 32'h8);
    check("release_inst", id_inst_o, {mem_word(32'h8), mem_word(32'hC)});

    // branch in FETCH_HI with a coincident ack
    for (int k = 0; k < 8 && m_phase != PH_HI; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      wait_edge();
    end
    step(1'b0, 1'b0, 1'b1, 32'h100);
    wait_edge();
    check("br_addr0", imem_addr_o, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("br_addr1", imem_addr_o, 32'h104);

    // flush while presenting and stalled
    for (int k = 0; k < 20 && !id_valid_o; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      wait_edge();
    end
    check("flush_setup_valid", id_valid_o, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h2460);
    wait_edge();
    check("flush_valid", id_valid_o, 1'b0);
    check("flush_inst", id_inst_o, 64'h0);
    check("flush_addr", imem_addr_o, 32'h2460);

    // three wait cycles on each word
    w_lo = 3; w_hi = 3;
    step(1'b0, 1'b1, 1'b0, 32'h200);
    wleft = 3;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      wait_edge();
      if (id_valid_o) begin lat = k; break; end
    end
    check("delay3_latency", 64'(lat), 64'd8);

    // PC wrap at the top of the address space
    w_lo = 0; w_hi = 0;
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0);
    wleft = 0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("wrap_pc", id_pc_o, 32'hFFFF_FFF8);
    check("wrap_addr", imem_addr_o, 32'h0);

    // randomized traffic
    w_lo = 0; w_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      r_st = ($urandom_range(99, 0) < 35);
      r_fl = ($urandom_range(99, 0) < 2);
      r_br = ($urandom_range(99, 0) < 4);
      r_tgt = $urandom();
      if ($urandom_range(3, 0) == 0) r_tgt = r_tgt | 32'hFFFF_FF00;
      r_tgt = r_tgt & 32'hFFFF_FFF8;
      step(r_st, r_fl, r_br, r_tgt);
    end

    // reset in the middle of an outstanding request
    w_lo = 5; w_hi = 5;
    step(1'b0, 1'b1, 1'b0, 32'h500);
    wleft = 5;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_abandon_req", imem_req_o, 1'b0);
    check("rst_abandon_addr", imem_addr_o, PC_RST);
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    wait_edge();
    check("rst_late_ack_valid", id_valid_o, 1'b0);
    imem_ack_i = 1'b0;
    w_lo = 0; w_hi = 0; wleft = 0;
    release_rst();
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();

`ifdef IF_ACK_TIMEOUT_EN
    step(1'b0, 1'b1, 1'b0, 32'h300);
    no_ack = 1'b1;
    repeat (TO) step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("to_err", fetch_err_o, 1'b1);
    check("to_req", imem_req_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    check("to_idle_req", imem_req_o, 1'b0);
    no_ack = 1'b0;
    step(1'b0, 1'b1, 1'b0, 32'h40);
    wait_edge();
    check("to_clear_err", fetch_err_o, 1'b0);
    check("to_clear_req", imem_req_o, 1'b1);
    check("to_clear_addr", imem_addr_o, 32'h40);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
